// File: rtl/id_stage.sv
// Instruction decode stage: decodes the IF/ID instruction, resolves jumps and branches,
// reads operands from the external register store and registers the ID/EX bundle.
module id_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pipe_pc,
    input  logic [31:0] pipe_pc4,
    input  logic [31:0] pipe_data,
    input  logic        op_write,
    input  logic [31:0] write_addr,
    input  logic [31:0] write_data,
    input  logic [31:0] load_pc_reg_value1,
    input  logic [31:0] load_pc_reg_value2,
    output logic [31:0] load_pc_reg_addr1,
    output logic [31:0] load_pc_reg_addr2,
    output logic [31:0] write_pc_reg_addr,
    output logic [31:0] write_pc_reg_value,
    output logic        control_j,
    output logic [31:0] pc_j,
    output logic [8:0]  ctrl_ex,
    output logic [31:0] pc4_ex,
    output logic [31:0] r_data1,
    output logic [31:0] r_data2,
    output logic [31:0] extended,
    output logic [31:0] rd_ex
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [31:0] w_immI;
    logic [31:0] w_immS;
    logic [31:0] w_immB;
    logic [31:0] w_immJ;
    logic [11:0] w_ctrl;
    logic [31:0] w_imm;
    logic        w_isJal;
    logic        w_isJalr;
    logic        w_isBranch;
    logic        w_branchCond;
    logic        w_jump;
    logic [31:0] w_writeAddrX4;

    assign w_opcode = pipe_data[6:0];
    assign w_rd     = pipe_data[11:7];
    assign w_funct3 = pipe_data[14:12];
    assign w_rs1    = pipe_data[19:15];
    assign w_rs2    = pipe_data[24:20];
    assign w_funct7 = pipe_data[31:25];

    assign load_pc_reg_addr1 = {25'b0, w_rs1, 2'b00};
    assign load_pc_reg_addr2 = {25'b0, w_rs2, 2'b00};

    // x0 reads as zero whatever the external store returns.
    assign w_op1 = (w_rs1 == 5'd0) ? 32'd0 : load_pc_reg_value1;
    assign w_op2 = (w_rs2 == 5'd0) ? 32'd0 : load_pc_reg_value2;

    assign w_immI = {{20{pipe_data[31]}}, pipe_data[31:20]};
    assign w_immS = {{20{pipe_data[31]}}, pipe_data[31:25], pipe_data[11:7]};
    assign w_immB = {{19{pipe_data[31]}}, pipe_data[31], pipe_data[7],
                     pipe_data[30:25], pipe_data[11:8], 1'b0};
    assign w_immJ = {{11{pipe_data[31]}}, pipe_data[31], pipe_data[19:12],
                     pipe_data[20], pipe_data[30:21], 1'b0};

    always_comb begin
        w_ctrl     = '0;
        w_imm      = '0;
        w_isJal    = 1'b0;
        w_isJalr   = 1'b0;
        w_isBranch = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                case ({w_funct7, w_funct3})
                    {7'b0000000, 3'b000}: w_ctrl = 12'b000_100_00_0000;
                    {7'b0100000, 3'b000}: w_ctrl = 12'b000_100_00_0010;
                    {7'b0000000, 3'b001}: w_ctrl = 12'b000_100_00_1000;
                    {7'b0000000, 3'b010}: w_ctrl = 12'b000_100_00_1010;
                    {7'b0000000, 3'b111}: w_ctrl = 12'b000_100_00_0100;
                    {7'b0000000, 3'b110}: w_ctrl = 12'b000_100_00_0110;
                    default: w_ctrl = '0;
                endcase
            end
            OP_ADDI: if (w_funct3 == 3'b000) begin
                w_ctrl = 12'b000_100_00_0001;
                w_imm  = w_immI;
            end
            OP_LOAD: if (w_funct3 == 3'b011) begin
                w_ctrl = 12'b000_101_10_0001;
                w_imm  = w_immI;
            end
            OP_STORE: if (w_funct3 == 3'b011) begin
                w_ctrl = 12'b000_000_01_0001;
                w_imm  = w_immS;
            end
            OP_JALR: if (w_funct3 == 3'b000) begin
                w_ctrl   = 12'b001_110_00_0000;
                w_imm    = w_immI;
                w_isJalr = 1'b1;
            end
            OP_BRANCH: if (w_funct3 == 3'b000 || w_funct3 == 3'b001 ||
                           w_funct3 == 3'b100 || w_funct3 == 3'b101) begin
                w_ctrl     = 12'b100_000_00_0000;
                w_imm      = w_immB;
                w_isBranch = 1'b1;
            end
            OP_JAL: begin
                w_ctrl  = 12'b010_110_00_0000;
                w_imm   = w_immJ;
                w_isJal = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    // BLT/BGE compare operands as signed two's-complement values.
    assign w_branchCond = (w_funct3 == 3'b000) ? (w_op1 == w_op2) :
                          (w_funct3 == 3'b001) ? (w_op1 != w_op2) :
                          (w_funct3 == 3'b100) ? ($signed(w_op1) < $signed(w_op2)) :
                                                 ($signed(w_op1) >= $signed(w_op2));

    assign w_jump    = w_isJal | w_isJalr | (w_isBranch & w_branchCond);
    assign control_j = ~reset_n & w_jump;
    assign pc_j      = !control_j ? 32'd0 :
                       w_isJalr   ? ((w_op1 + w_imm) & ~32'd1) :
                                    (pipe_pc + w_imm);

    assign w_writeAddrX4      = write_addr << 2;
    assign write_pc_reg_addr  = (op_write && write_addr != 32'd0) ? w_writeAddrX4 : 32'd0;
    assign write_pc_reg_value = (op_write && write_addr != 32'd0) ? write_data : 32'd0;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            ctrl_ex  <= '0;
            pc4_ex   <= '0;
            r_data1  <= '0;
            r_data2  <= '0;
            extended <= '0;
            rd_ex    <= '0;
        end else begin
            ctrl_ex  <= w_ctrl[8:0];
            pc4_ex   <= pipe_pc4;
            r_data1  <= w_op1;
            r_data2  <= w_op2;
            extended <= w_imm;
            rd_ex    <= {27'b0, w_rd};
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: combinational jump/address outputs are checked in the
// drive cycle, the registered ID/EX bundle is queued and checked one edge later.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pipe_pc, pipe_pc4, pipe_data;
    logic        op_write;
    logic [31:0] write_addr, write_data;
    logic [31:0] load_pc_reg_value1, load_pc_reg_value2;
    logic [31:0] load_pc_reg_addr1, load_pc_reg_addr2;
    logic [31:0] write_pc_reg_addr, write_pc_reg_value;
    logic        control_j;
    logic [31:0] pc_j;
    logic [8:0]  ctrl_ex;
    logic [31:0] pc4_ex, r_data1, r_data2, extended, rd_ex;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [8:0]  ctrl;
        logic [31:0] pc4;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] ext;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];

    id_stage dut (
        .clk(clk), .reset_n(reset_n),
        .pipe_pc(pipe_pc), .pipe_pc4(pipe_pc4), .pipe_data(pipe_data),
        .op_write(op_write), .write_addr(write_addr), .write_data(write_data),
        .load_pc_reg_value1(load_pc_reg_value1), .load_pc_reg_value2(load_pc_reg_value2),
        .load_pc_reg_addr1(load_pc_reg_addr1), .load_pc_reg_addr2(load_pc_reg_addr2),
        .write_pc_reg_addr(write_pc_reg_addr), .write_pc_reg_value(write_pc_reg_value),
        .control_j(control_j), .pc_j(pc_j),
        .ctrl_ex(ctrl_ex), .pc4_ex(pc4_ex), .r_data1(r_data1), .r_data2(r_data2),
        .extended(extended), .rd_ex(rd_ex)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic exp_t mkExp(logic [8:0] c, logic [31:0] p4, logic [31:0] a, logic [31:0] b,
                                   logic [31:0] e, logic [31:0] r);
        exp_t x;
        x.ctrl = c; x.pc4 = p4; x.d1 = a; x.d2 = b; x.ext = e; x.rd = r;
        return x;
    endfunction

    function automatic logic [31:0] encI(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                         logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] encB(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] encJ(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] encR(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [31:0] v1, input logic [31:0] v2,
                                 input logic expJ, input logic [31:0] expPcj, input exp_t e);
        @(negedge clk);
        pipe_pc            = pc;
        pipe_pc4           = pc + 32'd4;
        pipe_data          = instr;
        load_pc_reg_value1 = v1;
        load_pc_reg_value2 = v2;
        #1;
        checkOutput("control_j", {31'b0, control_j}, {31'b0, expJ});
        checkOutput("pc_j", pc_j, expPcj);
        sb.push_back(e);
    endtask

    task automatic applyWrite(input logic op, input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] expAddr, input logic [31:0] expVal);
        op_write   = op;
        write_addr = addr;
        write_data = data;
        #1;
        checkOutput("wr_addr", write_pc_reg_addr, expAddr);
        checkOutput("wr_value", write_pc_reg_value, expVal);
    endtask

    // Registered outputs are compared one cycle after their stimulus was queued.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("ctrl_ex", {23'b0, ctrl_ex}, {23'b0, e.ctrl});
            checkOutput("pc4_ex", pc4_ex, e.pc4);
            checkOutput("r_data1", r_data1, e.d1);
            checkOutput("r_data2", r_data2, e.d2);
            checkOutput("extended", extended, e.ext);
            checkOutput("rd_ex", rd_ex, e.rd);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] rF3 [4];
        logic [8:0] rCtrl [4];
        rF3   = '{3'b001, 3'b010, 3'b111, 3'b110};
        rCtrl = '{9'b100001000, 9'b100001010, 9'b100000100, 9'b100000110};

        reset_n = 1'b1; op_write = 1'b0; write_addr = '0; write_data = '0;
        pipe_pc = '0; pipe_pc4 = '0; pipe_data = '0;
        load_pc_reg_value1 = '0; load_pc_reg_value2 = '0;

        $display("[TB] reset with a JAL presented");
        applyStimulus(32'h1000, encJ(21'h000800, 5'd1), 32'h1234, 32'h5678, 1'b0, 32'd0,
                      mkExp(9'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0));
        applyWrite(1'b1, 32'd12, 32'd15, 32'd48, 32'd15);
        @(negedge clk);
        reset_n = 1'b0;

        $display("[TB] ADDI / LD / SD");
        applyStimulus(32'd400, encI(12'd7, 5'd20, 3'b000, 5'd12, 7'b0010011), 32'd8, 32'h55, 1'b0, 32'd0,
                      mkExp(9'b100000001, 32'd404, 32'd8, 32'h55, 32'd7, 32'd12));
        checkOutput("addr1", load_pc_reg_addr1, 32'd80);
        checkOutput("addr2", load_pc_reg_addr2, 32'd28);
        applyStimulus(32'd500, encI(12'hFFC, 5'd2, 3'b011, 5'd5, 7'b0000011), 32'h1000, 32'h33, 1'b0, 32'd0,
                      mkExp(9'b101100001, 32'd504, 32'h1000, 32'h33, 32'hFFFFFFFC, 32'd5));
        applyStimulus(32'd508, encS(12'd12, 5'd7, 5'd3, 3'b011), 32'h2000, 32'h44, 1'b0, 32'd0,
                      mkExp(9'b000010001, 32'd512, 32'h2000, 32'h44, 32'd12, 32'd12));

        $display("[TB] branches");
        applyStimulus(32'd100, encB(13'd16, 5'd2, 5'd1, 3'b000), 32'd5, 32'd5, 1'b1, 32'd116,
                      mkExp(9'd0, 32'd104, 32'd5, 32'd5, 32'd16, 32'd16));
        applyStimulus(32'd100, encB(13'd16, 5'd2, 5'd1, 3'b000), 32'd5, 32'd6, 1'b0, 32'd0,
                      mkExp(9'd0, 32'd104, 32'd5, 32'd6, 32'd16, 32'd16));
        applyStimulus(32'd100, encB(13'd16, 5'd2, 5'd1, 3'b001), 32'd5, 32'd6, 1'b1, 32'd116,
                      mkExp(9'd0, 32'd104, 32'd5, 32'd6, 32'd16, 32'd16));
        applyStimulus(32'd200, encB(13'h1FF8, 5'd2, 5'd1, 3'b100), 32'hFFFFFFFD, 32'd2, 1'b1, 32'd192,
                      mkExp(9'd0, 32'd204, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFF8, 32'd25));
        applyStimulus(32'd200, encB(13'h1FF8, 5'd2, 5'd1, 3'b101), 32'hFFFFFFFD, 32'd2, 1'b0, 32'd0,
                      mkExp(9'd0, 32'd204, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFF8, 32'd25));
        applyStimulus(32'd200, encB(13'h1FF8, 5'd2, 5'd1, 3'b101), 32'd2, 32'hFFFFFFFD, 1'b1, 32'd192,
                      mkExp(9'd0, 32'd204, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFF8, 32'd25));

        $display("[TB] jumps");
        applyStimulus(32'h200, encI(12'd8, 5'd3, 3'b000, 5'd1, 7'b1100111), 32'h101, 32'h66, 1'b1, 32'h108,
                      mkExp(9'b110000000, 32'h204, 32'h101, 32'h66, 32'd8, 32'd1));
        applyStimulus(32'h1000, encJ(21'h000800, 5'd1), 32'hAAAA, 32'h77, 1'b1, 32'h1800,
                      mkExp(9'b110000000, 32'h1004, 32'd0, 32'h77, 32'h800, 32'd1));

        $display("[TB] R-type and NOP");
        applyStimulus(32'd600, encR(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3), 32'd10, 32'd3, 1'b0, 32'd0,
                      mkExp(9'b100000010, 32'd604, 32'd10, 32'd3, 32'd0, 32'd3));
        applyStimulus(32'd604, encR(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd4), 32'h99, 32'h88, 1'b0, 32'd0,
                      mkExp(9'b100000000, 32'd608, 32'd0, 32'd0, 32'd0, 32'd4));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'd700, encR(7'b0000000, 5'd2, 5'd1, rF3[i], 5'd9), 32'd21, 32'd22, 1'b0, 32'd0,
                          mkExp(rCtrl[i], 32'd704, 32'd21, 32'd22, 32'd0, 32'd9));
        end
        applyStimulus(32'd800, encR(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd3), 32'd1, 32'd2, 1'b0, 32'd0,
                      mkExp(9'd0, 32'd804, 32'd1, 32'd2, 32'd0, 32'd3));
        applyStimulus(32'd900, 32'hFFFFFFFF, 32'd11, 32'd12, 1'b0, 32'd0,
                      mkExp(9'd0, 32'd904, 32'd11, 32'd12, 32'd0, 32'd31));

        $display("[TB] writeback path");
        applyWrite(1'b1, 32'd12, 32'd15, 32'd48, 32'd15);
        applyWrite(1'b1, 32'd0, 32'd15, 32'd0, 32'd0);
        applyWrite(1'b0, 32'd7, 32'd99, 32'd0, 32'd0);
        applyWrite(1'b1, 32'd31, 32'hDEADBEEF, 32'd124, 32'hDEADBEEF);

        repeat (3) @(negedge clk);
        checkOutput("sb_drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
